// File: rtl/eth_tx_arb.sv
// Two-requester RMII TX arbiter: grants the TX path, enforces the inter-frame gap and aborts stuck frames.
// Define ETH_TX_ARB_PRIO_EN for fixed priority (Req[0] wins ties); default build is round robin.
module eth_tx_arb #(
  parameter int unsigned pIfg_Cnt     = 48,
  parameter logic [15:0] pTimeout_Cnt = 16'd8192
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [1:0]  Req,
  input  logic        Tx_Busy,
  input  logic        Tx_Done,
  output logic [1:0]  Grant,
  output logic        Eth_En,
  output logic        Timeout,
  output logic [1:0]  Arb_State,
  output logic [15:0] Frame_Cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_IFG   = 2'd3
  } state_t;

  localparam int unsigned IfgW    = (pIfg_Cnt > 1) ? $clog2(pIfg_Cnt) : 1;
  localparam logic [IfgW-1:0] IfgLast = IfgW'(pIfg_Cnt - 1);
  localparam logic [15:0] WdLast  = pTimeout_Cnt - 16'd1;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             timeout_q, timeout_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [15:0]      wd_q, wd_d;
  logic [IfgW-1:0]  ifg_q, ifg_d;
`ifndef ETH_TX_ARB_PRIO_EN
  logic             last_q, last_d;
`endif

  logic [1:0] win;
  logic       start_ok;
  logic       done_evt;
  logic       expire_evt;
  logic       ifg_end;

  always_comb begin
    win = 2'b00;
    case (Req)
      2'b01: win = 2'b01;
      2'b10: win = 2'b10;
      2'b11: begin
`ifdef ETH_TX_ARB_PRIO_EN
        win = 2'b01;
`else
        // last_q holds the index of the previous owner; the other requester wins the tie
        win = last_q ? 2'b01 : 2'b10;
`endif
      end
      default: win = 2'b00;
    endcase
  end

  assign start_ok   = (state_q == S_IDLE) && (Req != 2'b00) && !Tx_Busy;
  assign done_evt   = (state_q == S_BUSY) && Tx_Done;
  assign expire_evt = (state_q == S_BUSY) && !Tx_Done && (wd_q == WdLast);
  assign ifg_end    = (state_q == S_IFG) && (ifg_q == IfgLast);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_START;
      S_START: state_d = S_BUSY;
      S_BUSY:  if (done_evt || expire_evt) state_d = S_IFG;
      S_IFG:   if (ifg_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d     = grant_q;
    timeout_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    wd_d        = wd_q;
    ifg_d       = ifg_q;
`ifndef ETH_TX_ARB_PRIO_EN
    last_d      = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        wd_d = '0;
        if (start_ok) grant_d = win;
      end
      S_START: begin
        wd_d = wd_q + 16'd1;
      end
      S_BUSY: begin
        // Tx_Done takes precedence over a watchdog expiry in the same cycle
        if (done_evt || expire_evt) begin
          grant_d     = 2'b00;
          wd_d        = '0;
          ifg_d       = '0;
          timeout_d   = expire_evt;
          frame_cnt_d = done_evt ? frame_cnt_q + 16'd1 : frame_cnt_q;
`ifndef ETH_TX_ARB_PRIO_EN
          last_d      = grant_q[1];
`endif
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      S_IFG: begin
        ifg_d = ifg_end ? '0 : ifg_q + IfgW'(1);
      end
      default: begin
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      grant_q     <= 2'b00;
      timeout_q   <= 1'b0;
      frame_cnt_q <= '0;
      wd_q        <= '0;
      ifg_q       <= '0;
`ifndef ETH_TX_ARB_PRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      grant_q     <= grant_d;
      timeout_q   <= timeout_d;
      frame_cnt_q <= frame_cnt_d;
      wd_q        <= wd_d;
      ifg_q       <= ifg_d;
`ifndef ETH_TX_ARB_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

  assign Grant     = grant_q;
  assign Eth_En    = (state_q == S_START);
  assign Timeout   = timeout_q;
  assign Arb_State = state_q;
  assign Frame_Cnt = frame_cnt_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Randomized scoreboard bench for eth_tx_arb: a driver predicts each grant and frame end,
// a negedge monitor pops and compares whenever the arbiter starts or finishes a frame.
module tb_eth_tx_arb;

  localparam int IFG = 48;
  localparam int TO  = 100;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [1:0]  Req;
  logic        Tx_Busy;
  logic        Tx_Done;
  logic [1:0]  Grant;
  logic        Eth_En;
  logic        Timeout;
  logic [1:0]  Arb_State;
  logic [15:0] Frame_Cnt;

  eth_tx_arb #(.pIfg_Cnt(IFG), .pTimeout_Cnt(16'(TO))) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Tx_Busy(Tx_Busy), .Tx_Done(Tx_Done),
    .Grant(Grant), .Eth_En(Eth_En), .Timeout(Timeout), .Arb_State(Arb_State),
    .Frame_Cnt(Frame_Cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit         is_end;
    logic [1:0] grant;
    logic [15:0] cnt;
    bit         to;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 0;

  // reference model state
  int   last_idx = 1;
  int   model_cnt = 0;
  int   idle_at = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [1:0] model_pick(input logic [1:0] r);
    if (r != 2'b11) return r;
`ifdef ETH_TX_ARB_PRIO_EN
    return 2'b01;
`else
    return (last_idx == 1) ? 2'b01 : 2'b10;
`endif
  endfunction

  // mode 0: Tx_Done at start+len, mode 1: let the watchdog fire, mode 2: reset at start+len
  task automatic run_frame(input logic [1:0] req, input int busy_cyc, input int mode,
                           input int len, input bit drop_req, input bit noise);
    int t_free, exp_start, e_cyc, waited;
    logic [1:0] win;
    Req = req;
    Tx_Busy = (busy_cyc > 0);
    repeat (busy_cyc) tick();
    Tx_Busy = 1'b0;
    t_free = cyc;
    exp_start = ((t_free > idle_at) ? t_free : idle_at) + 1;
    win = model_pick(req);
    exp_q.push_back('{is_end: 1'b0, grant: win, cnt: 16'h0, to: 1'b0});
    waited = 0;
    while (Eth_En !== 1'b1) begin
      if (waited == 400) begin
        errors++;
        $display("FAIL start_wait: no Eth_En within 400 cycles, expected at cycle %0d", exp_start);
        finish_sim();
      end
      tick();
      waited++;
    end
    check("start_cycle", cyc, exp_start);
    e_cyc = cyc;
    if (drop_req) Req = 2'b00;
    if (noise) Tx_Done = 1'b1;
    tick();
    Tx_Done = 1'b0;
    check("eth_en_one_cycle", {31'd0, Eth_En}, 0);
    check("busy_after_start", Arb_State, 2);
    case (mode)
      0: begin
        exp_q.push_back('{is_end: 1'b1, grant: 2'b00, cnt: 16'((model_cnt + 1) % 65536), to: 1'b0});
        while (cyc < e_cyc + len) tick();
        Tx_Done = 1'b1;
        tick();
        Tx_Done = 1'b0;
        model_cnt = (model_cnt + 1) % 65536;
        last_idx = win[1] ? 1 : 0;
        idle_at = cyc + IFG;
      end
      1: begin
        exp_q.push_back('{is_end: 1'b1, grant: 2'b00, cnt: 16'(model_cnt), to: 1'b1});
        while (cyc < e_cyc + TO) tick();
        check("timeout_cycle", {31'd0, Timeout}, 1);
        check("timeout_grant", Grant, 0);
        last_idx = win[1] ? 1 : 0;
        idle_at = cyc + IFG;
      end
      default: begin
        while (cyc < e_cyc + len) tick();
        Rst = 1'b1;
        Req = 2'b00;
        tick();
        Rst = 1'b0;
        check("rst_grant", Grant, 0);
        check("rst_state", Arb_State, 0);
        check("rst_frame_cnt", Frame_Cnt, 0);
        check("rst_timeout", {31'd0, Timeout}, 0);
        check("rst_eth_en", {31'd0, Eth_En}, 0);
        model_cnt = 0;
        last_idx = 1;
        idle_at = cyc;
      end
    endcase
    if (noise) begin
      Tx_Done = 1'b1;
      tick();
      Tx_Done = 1'b0;
    end
    Req = 2'b00;
  endtask

  // monitor: frame starts and frame ends pop the scoreboard
  logic [1:0] prev_state = 2'd0;
  always @(negedge Clk) begin
    if (mon_en) begin
      exp_t rec;
      check("grant_onehot", {31'd0, $onehot0(Grant)}, 1);
      if (Grant != 2'b00) check("grant_state", {31'd0, Arb_State inside {2'd1, 2'd2}}, 1);
      if (Eth_En) begin
        if (exp_q.size() == 0) begin
          check("unexpected_start", 1, 0);
        end else begin
          rec = exp_q.pop_front();
          check("start_kind", {31'd0, rec.is_end}, 0);
          check("grant", Grant, rec.grant);
        end
      end
      if (prev_state == 2'd2 && Arb_State == 2'd3) begin
        if (exp_q.size() == 0) begin
          check("unexpected_end", 1, 0);
        end else begin
          rec = exp_q.pop_front();
          check("end_kind", {31'd0, rec.is_end}, 1);
          check("end_frame_cnt", Frame_Cnt, rec.cnt);
          check("end_timeout", {31'd0, Timeout}, {31'd0, rec.to});
          check("end_grant", Grant, 0);
        end
      end else if (Timeout !== 1'b0) begin
        check("spurious_timeout", {31'd0, Timeout}, 0);
      end
      prev_state = Arb_State;
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout: bench did not complete, got cycle %0d", cyc);
    finish_sim();
  end

  initial begin
    Rst = 1'b1;
    Req = 2'b00;
    Tx_Busy = 1'b0;
    Tx_Done = 1'b0;
    repeat (3) tick();
    Rst = 1'b0;
    check("reset_grant", Grant, 0);
    check("reset_eth_en", {31'd0, Eth_En}, 0);
    check("reset_timeout", {31'd0, Timeout}, 0);
    check("reset_state", Arb_State, 0);
    check("reset_frame_cnt", Frame_Cnt, 0);
    idle_at = cyc;
    mon_en = 1'b1;

    run_frame(2'b01, 0, 0, 20, 0, 0);
    run_frame(2'b01, 0, 0, 3, 0, 0);
    repeat (3) run_frame(2'b11, 0, 0, 10, 0, 0);
    run_frame(2'b10, 0, 1, 0, 0, 1);
    run_frame(2'b01, 0, 0, TO - 1, 0, 0);
    run_frame(2'b11, 0, 0, TO - 1, 1, 1);

    for (int i = 0; i < 40; i++) begin
      int sel, b, ln;
      sel = int'($urandom_range(0, 9));
      b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 70)) : 0;
      ln = (sel == 1) ? TO - 1 : int'($urandom_range(1, 60));
      run_frame(2'($urandom_range(1, 3)), b, (sel == 0) ? 1 : 0, ln,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    run_frame(2'b11, 0, 2, 5, 0, 0);
    run_frame(2'b10, 10, 0, 8, 0, 0);
    run_frame(2'b11, 0, 0, 4, 0, 0);

    while (cyc < idle_at) tick();
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    tick();
    release dut.frame_cnt_q;
    model_cnt = 65535;
    run_frame(2'b01, 0, 0, 5, 0, 0);
    run_frame(2'b10, 0, 0, 5, 0, 0);

    repeat (IFG + 10) tick();
    check("queue_drained", exp_q.size(), 0);
    finish_sim();
  end

endmodule

// File: doc/eth_tx_arb.md
ETH_TX_ARB -- requirements
Module: eth_tx_arb

Interface
REQ-001 The block SHALL have a single clock, Clk, and a synchronous, active-high reset, Rst, sampled on the rising edge of Clk.
REQ-002 Parameter pIfg_Cnt, default 48, SHALL set the inter-frame gap in Clk cycles (96 bit times at 2 bits/clk).
REQ-003 Parameter pTimeout_Cnt, default 16'd8192, SHALL set the watchdog limit in cycles from grant to Tx_Done; legal range 2..65535.
REQ-004 Port Clk SHALL be an input, 1 bit: the 50 MHz RMII reference clock.
REQ-005 Port Rst SHALL be an input, 1 bit: synchronous active-high reset.
REQ-006 Port Req SHALL be an input, 2 bits: level frame request per requester; held high until granted.
REQ-007 Port Tx_Busy SHALL be an input, 1 bit: high while the TX control FSM is not IDLE.
REQ-008 Port Tx_Done SHALL be an input, 1 bit: one-cycle pulse from TX control on the last FCS cycle.
REQ-009 Port Grant SHALL be an output, 2 bits: one-hot owner of the TX path, held for the whole frame.
REQ-010 Port Eth_En SHALL be an output, 1 bit: one-cycle frame-start pulse to TX control.
REQ-011 Port Timeout SHALL be an output, 1 bit: one-cycle pulse on watchdog abort.
REQ-012 Port Arb_State SHALL be an output, 2 bits: current FSM state encoding.
REQ-013 Port Frame_Cnt SHALL be an output, 16 bits: count of completed frames, wrapping modulo 2^16.

Function
REQ-014 The FSM SHALL implement states IDLE=0, START=1, BUSY=2, IFG=3, with Arb_State reflecting the current state.
REQ-015 In IDLE, if Req is not 2'b00 and Tx_Busy=0 in cycle N, the block SHALL drive Grant to the one-hot winner and Eth_En=1 in cycle N+1 and enter START.
REQ-016 In IDLE with Tx_Busy=1, all requests SHALL be held off (no grant).
REQ-017 START SHALL last exactly one cycle (the Eth_En cycle), then the FSM SHALL enter BUSY; Eth_En SHALL be 0 in every other state.
REQ-018 In BUSY, Tx_Done=1 in cycle M SHALL give, in cycle M+1: Grant=0, Frame_Cnt incremented by 1, the winner recorded as last-granted, and state IFG.
REQ-019 A 16-bit watchdog SHALL count cycles in START and BUSY; on reaching pTimeout_Cnt-1 without Tx_Done, the next cycle SHALL have Timeout=1 (one cycle), Grant=0, Frame_Cnt unchanged, last-granted updated, and state IFG.
REQ-020 If Tx_Done and watchdog expiry coincide, Tx_Done SHALL win and Timeout SHALL stay 0.
REQ-021 IFG SHALL last exactly pIfg_Cnt cycles and then return to IDLE; the earliest next Eth_En SHALL be pIfg_Cnt+2 cycles after the Tx_Done cycle.
REQ-022 Arbitration with one requester active SHALL grant that requester; with both active it SHALL grant the requester not last granted (round robin).
REQ-023 Deassertion of Req during START, BUSY or IFG SHALL be ignored; the granted frame SHALL run to Tx_Done or timeout.
REQ-024 Tx_Done while in IDLE, START or IFG SHALL be ignored.
REQ-025 Grant SHALL never have more than one bit set, and SHALL be nonzero only in START and BUSY.
REQ-026 Frame_Cnt SHALL wrap from 16'hFFFF to 16'h0000 without side effects.

Reset
REQ-027 On Rst=1 the block SHALL set state=IDLE, Grant=0, Eth_En=0, Timeout=0, Frame_Cnt=0, watchdog=0, IFG counter=0, and last-granted=requester 1 (so requester 0 wins the first tie).
REQ-028 Rst asserted mid-frame SHALL abort immediately with all outputs at reset values in the following cycle, and SHALL NOT pulse Timeout.

Configuration
REQ-029 With macro ETH_TX_ARB_PRIO_EN defined, arbitration SHALL be fixed priority (Req[0] always wins ties) and the last-granted register SHALL be unused.
REQ-030 Without ETH_TX_ARB_PRIO_EN, arbitration SHALL be round robin per REQ-022; all other behaviour SHALL be identical.

Verification
REQ-031 After reset, Req=2'b01 with Tx_Busy=0 -> next cycle Grant=2'b01, Eth_En=1 for one cycle; Tx_Done 20 cycles later -> Grant=0, Frame_Cnt=1, Eth_En stays 0 for 48 cycles.
REQ-032 Req=2'b11 held over three frames (round robin) -> Grant sequence 01, 10, 01; with ETH_TX_ARB_PRIO_EN -> 01, 01, 01.
REQ-033 pTimeout_Cnt=100, no Tx_Done -> Timeout=1 exactly 100 cycles after Eth_En, Grant=0, Frame_Cnt unchanged, then IFG.
REQ-034 Tx_Done on the watchdog-expiry cycle -> Timeout=0, Frame_Cnt incremented.
REQ-035 Rst pulsed in BUSY -> next cycle Grant=0, Arb_State=0, Frame_Cnt=0, Timeout=0; Tx_Busy=1 in IDLE with Req=2'b10 -> no Grant until Tx_Busy=0.
REQ-036 Preload 65535 completed frames -> next Tx_Done wraps Frame_Cnt to 0.
